ternary_matvec: RTL and testbench
=================================

// Module: ternary_matvec
// PURPOSE
//  Ternary (-1/0/+1) matrix-vector multiply stage, directly downstream of RMS normalisation.
//  Latches one normalised D-element fixed-point vector and streams M weight rows from an
//  external weight memory, one row per cycle.
//  Produces an M-element saturated fixed-point output vector behind a valid/ready handshake.
// PARAMETERS
//  D      8   input vector length (elements per weight row); >=2
//  M      8   output vector length (weight rows); >=1
//  WIDTH  16  signed fixed-point element width (Q8.8); x and y use the same format
// PORTS
//  clk_i          in   1            clock; all state updates on posedge
//  rst_i          in   1            synchronous reset, active-high
//  in_valid_i     in   1            x_i valid
//  in_ready_o     out  1            block idle and can accept x_i
//  x_i            in   D*WIDTH      input vector; element k = x_i[k*WIDTH +: WIDTH]
//  w_rd_o         out  1            weight read strobe
//  w_addr_o       out  $clog2(M)    weight row address (use width 1 when M==1)
//  w_data_i       in   2*D          row data, 1-cycle read latency; weight k = w_data_i[2k+:2]
//  out_valid_o    out  1            y_o holds a complete result
//  out_ready_i    in   1            consumer accepts y_o
//  y_o            out  M*WIDTH      output vector; row r = y_o[r*WIDTH +: WIDTH]
//  sat_o          out  1            at least one row of the current result saturated
// BEHAVIOUR
//  Reset:
//  - Values while rst_i=1 and in the cycle after:
//    state=IDLE, in_ready_o=0 while rst_i=1, w_rd_o=0, w_addr_o=0, out_valid_o=0, y_o=0, sat_o=0.
//  - Reset mid-operation aborts immediately; the partial result is discarded (y_o cleared).
//  FSM IDLE -> RUN -> DONE -> IDLE:
//  - IDLE: in_ready_o=1. On in_valid_i&in_ready_o (edge E0): latch x_i, clear sat_o,
//    row counters := 0, go to RUN.
//  - RUN, issue side: cycles c=1..M after E0 drive w_rd_o=1, w_addr_o=c-1. w_rd_o=0 elsewhere.
//  - RUN, accumulate side: in cycles c=2..M+1, w_data_i holds row c-2; its result is
//    registered into y_o[row c-2] at the end of that cycle. Issue and accumulate overlap.
//  - RUN -> DONE after row M-1 is registered.
//  - DONE: cycle M+2 after E0, out_valid_o=1 and in_ready_o=0. y_o and sat_o are stable
//    while out_valid_o=1.
//  - DONE -> IDLE on out_ready_i; in_ready_o rises the following cycle.
//    Minimum period between accepts is M+3 cycles.
//  - y_o keeps the last result until overwritten row by row in the next RUN.
//    out_valid_o is the only qualifier for y_o.
//  Weight encoding (2 bits): 2'b00 -> 0, 2'b01 -> +1, 2'b11 -> -1, 2'b10 -> 0 (reserved).
//  Arithmetic:
//  - Row sum = sum over k of (+x[k] | -x[k] | 0), computed in a signed accumulator of
//    WIDTH+$clog2(D)+1 bits; never overflows.
//  - The binary point is unchanged (no rescaling).
//  - Result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; any saturated row sets sat_o
//    (sticky until the next accept).
//  - -x[k] with x[k] = most negative value is computed in the wide accumulator, so there
//    is no wrap.
//  Handshake rules:
//  - in_valid_i is ignored outside IDLE.
//  - out_ready_i is ignored outside DONE.
//  - x_i may change freely after E0.
//  - w_data_i is sampled only in accumulate cycles.
// TESTING
//  1 x all 0x0100 (1.0), D=8, all weights 2'b01 -> every y row 0x0800, sat_o=0;
//    out_valid_o exactly M+2 cycles after accept.
//  2 x[k]=k*0x0100, row r weights alternate +1/-1 starting at +1 -> y = 0xFC00 (-4.0)
//    for every row; all 2'b10 weights -> 0x0000.
//  3 x all 0x7FFF, weights +1 -> y 0x7FFF, sat_o=1; x all 0x8000, weights +1 -> y 0x8000,
//    sat_o=1; with weights -1 -> y 0x7FFF.
//  4 w_rd_o/w_addr_o sequence: addresses 0..M-1 on consecutive cycles, no gaps/repeats;
//    memory model row r = distinct pattern -> each y[r] matches the reference model.
//  5 Hold out_ready_i=0 for 10 cycles in DONE -> out_valid_o, y_o, sat_o stable,
//    in_ready_o=0, in_valid_i pulses ignored; release -> next accept after 1 IDLE cycle.
//  6 rst_i=1 at RUN cycle 3 -> next cycle w_rd_o=0, out_valid_o=0, y_o=0, IDLE;
//    a fresh vector then computes correctly.

Source files
------------

// File: rtl/ternary_matvec.sv
// Ternary (-1/0/+1) matrix-vector multiply: latches one x vector, streams M weight rows
// (one per cycle, 1-cycle read latency) and returns M saturated Q-format results.
module ternary_matvec #(
  parameter int D     = 8,
  parameter int M     = 8,
  parameter int WIDTH = 16,
  localparam int AW   = (M > 1) ? $clog2(M) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [D*WIDTH-1:0] x_i,
  output logic               w_rd_o,
  output logic [AW-1:0]      w_addr_o,
  input  logic [2*D-1:0]     w_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [M*WIDTH-1:0] y_o,
  output logic               sat_o
);

  localparam int ACCW = WIDTH + $clog2(D) + 1;
  localparam logic [AW-1:0] LAST_ROW = AW'(M - 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [D*WIDTH-1:0]    r_x;
  logic                  r_rd;
  logic [AW-1:0]         r_addr;
  logic                  r_acc_vld;
  logic [AW-1:0]         r_acc_row;
  logic                  r_sat;
  logic [WIDTH-1:0]      r_y [M];
  logic                  w_accept;
  logic signed [ACCW-1:0] w_acc;
  logic [WIDTH-1:0]      w_row_res;
  logic                  w_row_ovf;

  assign w_accept = (r_state == S_IDLE) && in_valid_i;

  // Handshake/strobe outputs are masked during reset so they read inactive immediately.
  assign in_ready_o  = (r_state == S_IDLE) && !rst_i;
  assign out_valid_o = (r_state == S_DONE) && !rst_i;
  assign w_rd_o      = r_rd && !rst_i;
  assign w_addr_o    = rst_i ? '0 : r_addr;
  assign sat_o       = r_sat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid_i) w_state_next = S_RUN;
      S_RUN:   if (r_acc_vld && (r_acc_row == LAST_ROW)) w_state_next = S_DONE;
      S_DONE:  if (out_ready_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Row sum in a wide accumulator: -x of the most negative value cannot wrap here.
  always_comb begin
    w_acc = '0;
    for (int k = 0; k < D; k++) begin
      case (w_data_i[2*k +: 2])
        2'b01:   w_acc = w_acc + {{(ACCW-WIDTH){r_x[k*WIDTH+WIDTH-1]}}, r_x[k*WIDTH +: WIDTH]};
        2'b11:   w_acc = w_acc - {{(ACCW-WIDTH){r_x[k*WIDTH+WIDTH-1]}}, r_x[k*WIDTH +: WIDTH]};
        default: ;
      endcase
    end
  end

  always_comb begin
    w_row_ovf = 1'b0;
    w_row_res = w_acc[WIDTH-1:0];
    if (w_acc > SAT_MAX) begin
      w_row_res = SAT_MAX[WIDTH-1:0];
      w_row_ovf = 1'b1;
    end else if (w_acc < SAT_MIN) begin
      w_row_res = SAT_MIN[WIDTH-1:0];
      w_row_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x       <= '0;
      r_rd      <= 1'b0;
      r_addr    <= '0;
      r_acc_vld <= 1'b0;
      r_acc_row <= '0;
      r_sat     <= 1'b0;
      for (int r = 0; r < M; r++) r_y[r] <= '0;
    end else begin
      if (w_accept) begin
        r_x    <= x_i;
        r_sat  <= 1'b0;
        r_rd   <= 1'b1;
        r_addr <= '0;
      end else if (r_rd) begin
        if (r_addr == LAST_ROW) begin
          r_rd   <= 1'b0;
          r_addr <= '0;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
      // The row read this cycle arrives next cycle; track which row it is.
      r_acc_vld <= r_rd;
      r_acc_row <= r_addr;
      if (r_acc_vld) begin
        r_y[r_acc_row] <= w_row_res;
        if (w_row_ovf) r_sat <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_y
      assign y_o[gi*WIDTH +: WIDTH] = r_y[gi];
    end
  endgenerate

endmodule

// File: tb/tb_ternary_matvec.sv
// Directed bench for ternary_matvec: weight memory model with 1-cycle latency,
// hand-computed vectors plus a small reference model for the mixed-pattern case.
module tb_ternary_matvec;
  localparam int D  = 8;
  localparam int M  = 8;
  localparam int W  = 16;
  localparam int AW = 3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [D*W-1:0]   x_i;
  logic             w_rd_o;
  logic [AW-1:0]    w_addr_o;
  logic [2*D-1:0]   w_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [M*W-1:0]   y_o;
  logic             sat_o;

  logic [2*D-1:0]   mem [M];
  int               n_checks = 0;
  int               n_fail   = 0;

  ternary_matvec #(.D(D), .M(M), .WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .x_i(x_i), .w_rd_o(w_rd_o), .w_addr_o(w_addr_o), .w_data_i(w_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .y_o(y_o), .sat_o(sat_o)
  );

  always #5 clk_i = ~clk_i;

  // Outside read responses the bus carries all -1 weights, so stray sampling shows up.
  always @(posedge clk_i) w_data_i <= w_rd_o ? mem[w_addr_o] : 16'hFFFF;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [M*W-1:0] obs, input logic [M*W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [2*D-1:0] v);
    for (int r = 0; r < M; r++) mem[r] = v;
  endtask

  function automatic void ref_vec(input logic [D*W-1:0] x, output logic [M*W-1:0] y,
                                  output logic s);
    int acc;
    int xv;
    logic [2*D-1:0] wr;
    s = 1'b0;
    y = '0;
    for (int r = 0; r < M; r++) begin
      acc = 0;
      wr  = mem[r];
      for (int k = 0; k < D; k++) begin
        xv = $signed(x[k*W +: W]);
        if (wr[2*k +: 2] == 2'b01) acc = acc + xv;
        else if (wr[2*k +: 2] == 2'b11) acc = acc - xv;
      end
      if (acc > 32767) begin acc = 32767; s = 1'b1; end
      else if (acc < -32768) begin acc = -32768; s = 1'b1; end
      y[r*W +: W] = 16'(acc);
    end
  endfunction

  task automatic accept(input string tag, input logic [D*W-1:0] x);
    check({tag, "_in_ready"}, in_ready_o, 1);
    in_valid_i = 1'b1;
    x_i = x;
    tick();
    in_valid_i = 1'b0;
    x_i = {D{16'hA5C3}};
  endtask

  task automatic run_txn(input string tag, input logic [D*W-1:0] x,
                         input logic [M*W-1:0] ey, input logic esat, input int hold);
    int c;
    int bad;
    logic [M*W-1:0] y_hold;
    logic [AW-1:0] ea;
    accept(tag, x);
    c = 1;
    bad = 0;
    while (!out_valid_o && c < 40) begin
      ea = AW'(c - 1);
      if (w_rd_o !== (c <= M)) bad++;
      else if (w_rd_o && (w_addr_o !== ea)) bad++;
      tick();
      c++;
    end
    check({tag, "_latency"}, c, M + 2);
    check({tag, "_rd_seq_errs"}, bad, 0);
    check({tag, "_y"}, y_o, ey);
    check({tag, "_sat"}, sat_o, esat);
    y_hold = ey;
    for (int h = 0; h < hold; h++) begin
      in_valid_i = h[0];
      x_i = {D{16'h1357}};
      tick();
      check({tag, "_hold_valid"}, out_valid_o, 1);
      check({tag, "_hold_ready"}, in_ready_o, 0);
      check({tag, "_hold_y"}, y_o, y_hold);
      check({tag, "_hold_sat"}, sat_o, esat);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check({tag, "_idle_ready"}, in_ready_o, 1);
    check({tag, "_idle_valid"}, out_valid_o, 0);
    $display("txn %s: latency=%0d y=%0h sat=%0b", tag, c, y_o, sat_o);
  endtask

  initial begin
    logic [D*W-1:0] x_ramp;
    logic [D*W-1:0] x_mix;
    logic [M*W-1:0] ey;
    logic es;

    rst_i = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    x_i = '0;
    set_mem(16'h5555);
    tick();
    tick();
    check("rst_in_ready", in_ready_o, 0);
    check("rst_w_rd", w_rd_o, 0);
    check("rst_w_addr", w_addr_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_y", y_o, 0);
    check("rst_sat", sat_o, 0);
    rst_i = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready_o, 1);
    check("post_rst_w_rd", w_rd_o, 0);

    // 1.0 * 8 rows of +1 -> 8.0
    run_txn("ones", {D{16'h0100}}, {M{16'h0800}}, 1'b0, 0);

    for (int k = 0; k < D; k++) x_ramp[k*W +: W] = 16'(k * 256);
    set_mem(16'hDDDD);
    run_txn("ramp_alt", x_ramp, {M{16'hFC00}}, 1'b0, 0);
    set_mem(16'hAAAA);
    run_txn("reserved", x_ramp, {M{16'h0000}}, 1'b0, 0);

    set_mem(16'h5555);
    run_txn("sat_pos", {D{16'h7FFF}}, {M{16'h7FFF}}, 1'b1, 0);
    run_txn("sat_neg", {D{16'h8000}}, {M{16'h8000}}, 1'b1, 0);
    set_mem(16'hFFFF);
    run_txn("neg_min", {D{16'h8000}}, {M{16'h7FFF}}, 1'b1, 0);

    mem[0] = 16'h1234; mem[1] = 16'hC3A5; mem[2] = 16'h0F0F; mem[3] = 16'hFFFF;
    mem[4] = 16'h5A5A; mem[5] = 16'h9D71; mem[6] = 16'h4444; mem[7] = 16'hE01B;
    x_mix = {16'h0080, 16'hFF00, 16'h0233, 16'hF9C0, 16'h1000, 16'h0001, 16'hE800, 16'h0555};
    ref_vec(x_mix, ey, es);
    run_txn("mixed", x_mix, ey, es, 0);

    // Back-pressure in DONE, then an immediate accept from the single IDLE cycle
    set_mem(16'hDDDD);
    run_txn("hold", x_ramp, {M{16'hFC00}}, 1'b0, 10);
    set_mem(16'h5555);
    run_txn("after_hold", {D{16'h0100}}, {M{16'h0800}}, 1'b0, 0);

    // Reset during RUN cycle 3
    accept("abort", {D{16'h0200}});
    tick();
    tick();
    check("abort_rd_before", w_rd_o, 1);
    rst_i = 1'b1;
    #1;
    check("abort_rd_in_rst", w_rd_o, 0);
    check("abort_ready_in_rst", in_ready_o, 0);
    tick();
    check("abort_w_rd", w_rd_o, 0);
    check("abort_out_valid", out_valid_o, 0);
    check("abort_y", y_o, 0);
    check("abort_sat", sat_o, 0);
    rst_i = 1'b0;
    tick();
    check("abort_idle", in_ready_o, 1);
    check("abort_idle_valid", out_valid_o, 0);
    $display("txn abort: y=%0h out_valid=%0b", y_o, out_valid_o);
    run_txn("fresh", {D{16'h0100}}, {M{16'h0800}}, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
